// File: rtl/bbox_tracker.sv
// bbox_tracker: sequences colour-bounding-box detection passes, double-buffers
// the captured box on frame boundaries, derives its centre and size, and
// overlays the box outline on a 640x480 RGB444 VGA pixel stream. The box
// lives in a 320x240 space, so pixel coordinates are halved before comparing.
module bbox_tracker #(
  parameter int          TIMEOUT_CYCLES = 2_000_000,
  parameter logic [11:0] BOX_COLOR      = 12'hF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_tick,
  output logic        start_flag,
  input  logic        done_flag,
  input  logic        error_flag,
  input  logic [8:0]  x_min,
  input  logic [8:0]  x_max,
  input  logic [8:0]  y_min,
  input  logic [8:0]  y_max,
  output logic        ack_flag,
  input  logic [9:0]  pix_col,
  input  logic [9:0]  pix_row,
  input  logic        video_on,
  input  logic [11:0] pixel_in,
  output logic [11:0] pixel_out,
  output logic        box_valid,
  output logic [8:0]  center_x,
  output logic [8:0]  center_y,
  output logic [8:0]  box_w,
  output logic [8:0]  box_h,
  output logic        timeout_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_LATCH, S_ACK} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          pending;
  logic          fail_hit;

  // Staging copy of the most recent filter result, and whether it is newer
  // than what is on screen.
  logic [8:0] stg_x_min, stg_x_max, stg_y_min, stg_y_max;
  logic       stg_valid, fresh;

  // Display copy; only changes on frame_tick so the outline never tears.
  logic [8:0] dsp_x_min, dsp_x_max, dsp_y_min, dsp_y_max;
  logic       dsp_valid;

  logic [9:0] sx, sy;
  logic       hit;

  // Next-state and handshake outputs, decoded from the current state only.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (that would infer a latch).
    state_nx   = state;
    start_flag = 1'b0;
    ack_flag   = 1'b0;
    fail_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && (frame_tick || pending)) state_nx = S_REQ;
      end
      S_REQ: begin
        start_flag = 1'b1;
        if (done_flag) begin
          state_nx = S_LATCH;
        end else if (error_flag || cnt == CNT_LAST) begin
          fail_hit = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_LATCH: state_nx = S_ACK;
      S_ACK: begin
        ack_flag = 1'b1;
        if (!done_flag) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register and per-pass wait counter (zero whenever not requesting).
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge.
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_REQ) cnt <= cnt + 1'b1;
      else                cnt <= '0;
    end
  end

  // One-deep memory of a tick that arrived while a pass was in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       pending <= 1'b0;
    else if (state == S_IDLE && state_nx == S_REQ)   pending <= 1'b0;
    else if (frame_tick && state != S_IDLE)          pending <= 1'b1;
  end

  // Sticky failure flag; informational only, passes keep running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         timeout_err <= 1'b0;
    else if (fail_hit) timeout_err <= 1'b1;
  end

  // Capture the filter result; a capture outranks a tick clearing fresh, so a
  // box latched in the same cycle as a tick still shows on the next tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_x_min <= '0;
      stg_x_max <= '0;
      stg_y_min <= '0;
      stg_y_max <= '0;
      stg_valid <= 1'b0;
      fresh     <= 1'b0;
    end else if (state == S_LATCH) begin
      stg_x_min <= x_min;
      stg_x_max <= x_max;
      stg_y_min <= y_min;
      stg_y_max <= y_max;
      stg_valid <= (x_min <= x_max) && (y_min <= y_max) &&
                   !(x_min == '0 && x_max == '0 && y_min == '0 && y_max == '0);
      fresh     <= 1'b1;
    end else if (frame_tick) begin
      fresh     <= 1'b0;
    end
  end

  // Publish the staged box at frame boundaries only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dsp_x_min <= '0;
      dsp_x_max <= '0;
      dsp_y_min <= '0;
      dsp_y_max <= '0;
      dsp_valid <= 1'b0;
    end else if (frame_tick && fresh) begin
      dsp_x_min <= stg_x_min;
      dsp_x_max <= stg_x_max;
      dsp_y_min <= stg_y_min;
      dsp_y_max <= stg_y_max;
      dsp_valid <= stg_valid;
    end
  end

  // Centre and size of the displayed box; zero when there is no valid box.
  always_comb begin
    box_valid = dsp_valid;
    center_x  = '0;
    center_y  = '0;
    box_w     = '0;
    box_h     = '0;
    if (dsp_valid) begin
      center_x = 9'(({1'b0, dsp_x_min} + {1'b0, dsp_x_max}) >> 1);
      center_y = 9'(({1'b0, dsp_y_min} + {1'b0, dsp_y_max}) >> 1);
      box_w    = dsp_x_max - dsp_x_min + 9'd1;
      box_h    = dsp_y_max - dsp_y_min + 9'd1;
    end
  end

  // Outline hit test in box space.
  always_comb begin
    sx  = pix_col >> 1;
    sy  = pix_row >> 1;
    hit = dsp_valid &&
          ((((sy == {1'b0, dsp_y_min}) || (sy == {1'b0, dsp_y_max})) &&
            (sx >= {1'b0, dsp_x_min}) && (sx <= {1'b0, dsp_x_max})) ||
           (((sx == {1'b0, dsp_x_min}) || (sx == {1'b0, dsp_x_max})) &&
            (sy >= {1'b0, dsp_y_min}) && (sy <= {1'b0, dsp_y_max})));
  end

  // Registered video output; black outside the active region.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          pixel_out <= '0;
    else if (!video_on) pixel_out <= '0;
    else if (hit)       pixel_out <= BOX_COLOR;
    else                pixel_out <= pixel_in;
  end

endmodule
